// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: boot sequencer for the single-cycle RISC-V core.
// Holds the core in reset, receives a length-prefixed image over the UART
// byte stream, assembles little-endian words into instruction memory and
// releases the core once the final word has been written. Bad lengths and
// stalled transfers park the block in a sticky error state with the core held.
module cpu_boot_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_err,
  output logic [15:0]       words_loaded
);

  // Idle counter must be able to represent TIMEOUT_CYC itself.
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  // Largest legal word count is the full memory, 2^ADDR_W words.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  logic [2:0]        state_q,     state_d;
  logic [1:0]        byte_idx_q,  byte_idx_d;
  logic [ADDR_W-1:0] word_idx_q,  word_idx_d;
  logic [IDLE_W-1:0] idle_q,      idle_d;
  logic              imem_we_q,   imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              boot_done_q, boot_done_d;
  logic              boot_err_q,  boot_err_d;
  logic [15:0]       words_q,     words_d;

  // Datapath-only registers: word count and the three low bytes of the word
  // being assembled. Their contents are always written before being used.
  logic [15:0] len_q, len_d;
  logic [23:0] asm_q, asm_d;

  logic [15:0] n_full;
  assign n_full = {rx_data, len_q[7:0]};

  // Next-state logic: byte acceptance, word assembly and idle timeout.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_idx_d   = word_idx_q;
    idle_d       = idle_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    words_d      = words_q;
    boot_err_d   = boot_err_q;
    len_d        = len_q;
    asm_d        = asm_q;
    // Core status follows the state one cycle later, so the final write
    // lands before the core leaves reset.
    cpu_reset_d  = (state_q != S_RUN);
    boot_done_d  = (state_q == S_RUN);

    case (state_q)
      S_LEN_LO: begin
        // No timeout here: the host may take arbitrarily long to start.
        if (rx_valid) begin
          len_d   = {8'h00, rx_data};
          idle_d  = '0;
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          len_d      = n_full;
          idle_d     = '0;
          byte_idx_d = 2'd0;
          word_idx_d = '0;
          if ({1'b0, n_full} > MAX_WORDS) begin
            state_d    = S_ERR;
            boot_err_d = 1'b1;
          end else if (n_full == 16'd0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DATA;
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d    = S_ERR;
          boot_err_d = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          idle_d     = '0;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q;
            imem_wdata_d = {rx_data, asm_q};
            words_d      = words_q + 16'd1;
            // Last-word detection uses the 16-bit count so a full-memory
            // image never wraps the address back to 0.
            if (words_q + 16'd1 == len_q) begin
              state_d = S_RUN;
            end else begin
              word_idx_d = word_idx_q + ADDR_W'(1);
            end
          end else begin
            // Bytes arrive LSB first; shifting in from the top leaves
            // {b2,b1,b0} after three bytes.
            asm_d = {rx_data, asm_q[23:8]};
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d    = S_ERR;
          boot_err_d = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      S_ERR: begin
        state_d     = S_ERR;
        cpu_reset_d = 1'b1;
        boot_err_d  = 1'b1;
      end
      default: begin
        state_d = S_LEN_LO;
      end
    endcase
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LEN_LO;
      byte_idx_q   <= 2'd0;
      word_idx_q   <= '0;
      idle_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cpu_reset_q  <= 1'b1;
      boot_done_q  <= 1'b0;
      boot_err_q   <= 1'b0;
      words_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      idle_q       <= idle_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      boot_done_q  <= boot_done_d;
      boot_err_q   <= boot_err_d;
      words_q      <= words_d;
    end
  end

  // Length and assembly registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    len_q <= len_d;
    asm_q <= asm_d;
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign boot_done    = boot_done_q;
  assign boot_err     = boot_err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl (ADDR_W=8, TIMEOUT_CYC=20).
module tb_cpu_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        boot_done;
  logic        boot_err;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  cpu_boot_ctrl #(.ADDR_W(8), .TIMEOUT_CYC(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .boot_done    (boot_done),
    .boot_err     (boot_err),
    .words_loaded (words_loaded)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Cycle counter and write log (sampled at the falling edge).
  int          cyc = 0;
  int          nwr = 0;
  int          wr_addr [2048];
  logic [31:0] wr_data [2048];
  int          wr_cyc  [2048];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr[nwr] <= int'(imem_addr);
      wr_data[nwr] <= imem_wdata;
      wr_cyc[nwr]  <= cyc;
      nwr          <= nwr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; the byte is taken at the next rising
  // edge and the task returns at the following falling edge.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int w0;
    int bad;
    logic [7:0]  stream3 [12];
    logic [31:0] exp3 [3];
    logic [31:0] wexp;

    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(2);
    chk("rst_we",    32'(imem_we),      32'd0);
    chk("rst_addr",  32'(imem_addr),    32'd0);
    chk("rst_wdata", imem_wdata,        32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_cpu",   32'(cpu_reset),    32'd1);
    chk("rst_done",  32'(boot_done),    32'd0);
    chk("rst_err",   32'(boot_err),     32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Normal two-word load, one byte every three cycles.
    send(8'h02); idle(2);
    send(8'h00); idle(2);
    send(8'h13); idle(2);
    send(8'h05); idle(2);
    send(8'hA0); idle(2);
    send(8'h00);
    chk("n_we0",    32'(imem_we),   32'd1);
    chk("n_addr0",  32'(imem_addr), 32'd0);
    chk("n_data0",  imem_wdata,     32'h00A00513);
    chk("n_cpu0",   32'(cpu_reset), 32'd1);
    idle(2);
    send(8'h6F); idle(2);
    send(8'h00); idle(2);
    send(8'h00); idle(2);
    send(8'h00);
    chk("n_we1",    32'(imem_we),      32'd1);
    chk("n_addr1",  32'(imem_addr),    32'd1);
    chk("n_data1",  imem_wdata,        32'h0000006F);
    chk("n_words",  32'(words_loaded), 32'd2);
    chk("n_cpu1",   32'(cpu_reset),    32'd1);
    @(negedge clk);
    chk("n_we_off", 32'(imem_we),   32'd0);
    chk("n_rel",    32'(cpu_reset), 32'd0);
    chk("n_done",   32'(boot_done), 32'd1);
    chk("n_err",    32'(boot_err),  32'd0);

    // Zero-length image.
    do_reset();
    w0 = nwr;
    send(8'h00);
    send(8'h00);
    chk("z_cpu_hold", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    chk("z_rel",  32'(cpu_reset), 32'd0);
    chk("z_done", 32'(boot_done), 32'd1);
    chk("z_err",  32'(boot_err),  32'd0);
    @(negedge clk);
    chk("z_nowr", 32'(nwr - w0), 32'd0);

    // Length overflow: N = 257.
    do_reset();
    w0 = nwr;
    send(8'h01);
    send(8'h01);
    chk("o_err_edge", 32'(boot_err), 32'd1);
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    idle(3);
    chk("o_nowr",  32'(nwr - w0),   32'd0);
    chk("o_cpu",   32'(cpu_reset),  32'd1);
    chk("o_done",  32'(boot_done),  32'd0);
    chk("o_err",   32'(boot_err),   32'd1);

    // Full-memory image: N = 256 at one byte per cycle.
    do_reset();
    w0 = nwr;
    send(8'h00);
    send(8'h01);
    for (int k = 0; k < 1024; k++) send(8'(k));
    chk("f_cpu_hold", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    chk("f_rel",   32'(cpu_reset),    32'd0);
    chk("f_words", 32'(words_loaded), 32'd256);
    chk("f_err",   32'(boot_err),     32'd0);
    @(negedge clk);
    chk("f_nwr", 32'(nwr - w0), 32'd256);
    bad = 0;
    for (int w = 0; w < 256; w++) begin
      wexp = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      if (wr_addr[w0+w] != w || wr_data[w0+w] !== wexp) bad++;
    end
    chk("f_bad_words", 32'(bad), 32'd0);

    // Timeout: two data bytes then silence.
    do_reset();
    w0 = nwr;
    send(8'h01);
    send(8'h00);
    send(8'hAA);
    send(8'hBB);
    idle(19);
    chk("t_err_early", 32'(boot_err), 32'd0);
    idle(1);
    chk("t_err",  32'(boot_err),  32'd1);
    chk("t_cpu",  32'(cpu_reset), 32'd1);
    chk("t_nowr", 32'(nwr - w0),  32'd0);

    // Long silence before the first byte is harmless.
    do_reset();
    idle(50);
    chk("i_err", 32'(boot_err), 32'd0);
    send(8'h00);
    send(8'h00);
    @(negedge clk);
    chk("i_rel", 32'(cpu_reset), 32'd0);
    chk("i_err2", 32'(boot_err), 32'd0);

    // Back-to-back three-word load.
    stream3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    exp3    = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
    do_reset();
    w0 = nwr;
    send(8'h03);
    send(8'h00);
    for (int i = 0; i < 12; i++) send(stream3[i]);
    @(negedge clk);
    chk("b_nwr", 32'(nwr - w0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b_addr%0d", i), 32'(wr_addr[w0+i]), 32'(i));
      chk($sformatf("b_data%0d", i), wr_data[w0+i], exp3[i]);
    end
    chk("b_gap01", 32'(wr_cyc[w0+1] - wr_cyc[w0]),   32'd4);
    chk("b_gap12", 32'(wr_cyc[w0+2] - wr_cyc[w0+1]), 32'd4);
    chk("b_rel",   32'(cpu_reset), 32'd0);

    // Reset in the middle of a load, then a fresh one-word load.
    do_reset();
    send(8'h03);
    send(8'h00);
    for (int i = 0; i < 5; i++) send(8'(i + 1));
    chk("r_words_pre", 32'(words_loaded), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("r_async_cpu",   32'(cpu_reset),    32'd1);
    chk("r_async_words", 32'(words_loaded), 32'd0);
    chk("r_async_done",  32'(boot_done),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(8'h01);
    send(8'h00);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    chk("r_we",   32'(imem_we),   32'd1);
    chk("r_addr", 32'(imem_addr), 32'd0);
    chk("r_data", imem_wdata,     32'hEFBEADDE);
    @(negedge clk);
    chk("r_rel",  32'(cpu_reset), 32'd0);
    chk("r_done", 32'(boot_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
